// File: rtl/countdown_pkg.sv
// Shared op-codes and state encoding for the countdown sequencer.
package countdown_pkg;

    // Command op-codes carried on cmd_op
    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_PAUSE  = 2'b01;
    localparam logic [1:0] OP_RESUME = 2'b10;
    localparam logic [1:0] OP_ABORT  = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/countdown_sequencer_tick_gen.sv
// Prescaler producing a one-cycle count tick every PRESCALE enabled cycles.
// The count is frozen while enable is low, so a pause resumes mid-period.
module tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    import countdown_pkg::*;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] psc_q;
    logic [PW-1:0] psc_d;

    // Tick is asserted on the last prescaler step of an enabled cycle
    always_comb begin
        tick = en && (psc_q == LAST);
    end

    // Next prescaler value: clear wins, wrap after the tick, otherwise hold
    always_comb begin
        psc_d = psc_q;
        if (clr) begin
            psc_d = '0;
        end else if (en) begin
            if (psc_q == LAST) begin
                psc_d = '0;
            end else begin
                psc_d = psc_q + PW'(1);
            end
        end else begin
            psc_d = psc_q;
        end
    end

    // Prescaler register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end

endmodule

// File: rtl/countdown_sequencer.sv
// Command-driven down-counter sequencer: START/PAUSE/RESUME/ABORT commands,
// prescaled decrement, terminal-count pulse, one-shot or auto-reload runs.
// Every output is a register; command effects appear one cycle after accept.
module countdown_sequencer #(
    parameter int WIDTH    = 6,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_value,
    input  logic             cmd_periodic,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired,
    output logic             tc_pulse,
    output logic             err_pulse
);
    import countdown_pkg::*;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             periodic_q, periodic_d;
    logic             tc_q, tc_d;
    logic             err_q, err_d;
    logic             busy_q, expired_q, ready_q;

    logic             cmd_accept_s;
    logic             tick_s;
    logic             tick_en_s;
    logic             tick_clr_s;

    // Command handshake and prescaler control; a coincident command
    // also freezes the prescaler so the discarded tick is not lost mid-period
    always_comb begin
        cmd_accept_s = cmd_valid && ready_q;
        tick_en_s    = (state_q == ST_RUN) && !cmd_accept_s;
        tick_clr_s   = cmd_accept_s && (cmd_op == OP_START);
    end

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en_s),
        .clr   (tick_clr_s),
        .tick  (tick_s)
    );

    // Next-state logic: accepted commands take priority over a tick
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        reload_d   = reload_q;
        periodic_d = periodic_q;
        tc_d       = 1'b0;
        err_d      = 1'b0;
        if (cmd_accept_s) begin
            case (cmd_op)
                OP_START: begin
                    if (cmd_value == '0) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                        count_d = '0;
                    end else begin
                        count_d    = cmd_value;
                        reload_d   = cmd_value;
                        periodic_d = cmd_periodic;
                        state_d    = ST_RUN;
                    end
                end
                OP_PAUSE: begin
                    if (state_q == ST_RUN) begin
                        state_d = ST_PAUSE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_RESUME: begin
                    if (state_q == ST_PAUSE) begin
                        state_d = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_ABORT: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
                default: begin
                    err_d = 1'b1;
                end
            endcase
        end else if (tick_s) begin
            if (count_q > ONE) begin
                count_d = count_q - ONE;
            end else if (count_q == ONE) begin
                tc_d = 1'b1;
                if (periodic_q) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = ST_DONE;
                end
            end else begin
                // A zero count in RUN cannot be reached; park safely in IDLE
                state_d = ST_IDLE;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            reload_q   <= '0;
            periodic_q <= 1'b0;
            tc_q       <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            expired_q  <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            reload_q   <= reload_d;
            periodic_q <= periodic_d;
            tc_q       <= tc_d;
            err_q      <= err_d;
            busy_q     <= (state_d == ST_RUN) || (state_d == ST_PAUSE);
            expired_q  <= (state_d == ST_DONE);
            ready_q    <= 1'b1;
        end
    end

    // Output mapping
    always_comb begin
        cmd_ready = ready_q;
        count     = count_q;
        busy      = busy_q;
        expired   = expired_q;
        tc_pulse  = tc_q;
        err_pulse = err_q;
    end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer: one DUT with PRESCALE=1 (u1) and one
// with PRESCALE=2 (u2) sharing clock, reset and command inputs.
module tb_countdown_sequencer;

    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_PAUSE  = 2'b01;
    localparam logic [1:0] OP_RESUME = 2'b10;
    localparam logic [1:0] OP_ABORT  = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [5:0] cmd_value = 6'd0;
    logic       cmd_periodic = 1'b0;

    logic       ready1, busy1, exp1, tc1, err1;
    logic [5:0] count1;
    logic       ready2, busy2, exp2, tc2, err2;
    logic [5:0] count2;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    countdown_sequencer #(.WIDTH(6), .PRESCALE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready1),
        .cmd_op(cmd_op), .cmd_value(cmd_value), .cmd_periodic(cmd_periodic),
        .count(count1), .busy(busy1), .expired(exp1), .tc_pulse(tc1), .err_pulse(err1)
    );

    countdown_sequencer #(.WIDTH(6), .PRESCALE(2)) u2 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready2),
        .cmd_op(cmd_op), .cmd_value(cmd_value), .cmd_periodic(cmd_periodic),
        .count(count2), .busy(busy2), .expired(exp2), .tc_pulse(tc2), .err_pulse(err2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [5:0] v, input logic p);
        cmd_valid    = 1'b1;
        cmd_op       = op;
        cmd_value    = v;
        cmd_periodic = p;
        cyc();
        cmd_valid    = 1'b0;
    endtask

    task automatic test_reset();
        cyc(); cyc();
        tests_run++;
        if ({ready1, busy1, exp1, tc1, err1, count1} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b, expected all 0", {ready1, busy1, exp1, tc1, err1, count1});
        end
        #2 rst_n = 1'b1;
        #1;
        tests_run++;
        if (ready1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_before_edge: got %b, expected 0", ready1);
        end
        cyc();
        tests_run++;
        if (ready1 !== 1'b1 || ready2 !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_release: got %b/%b, expected 1/1", ready1, ready2);
        end
        // reset in the middle of a run
        send(OP_START, 6'd20, 1'b1);
        cyc(); cyc();
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({ready1, busy1, exp1, tc1, err1, count1} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_midrun: got %b, expected all 0", {ready1, busy1, exp1, tc1, err1, count1});
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        tests_run++;
        if (ready1 !== 1'b1 || count1 !== 6'd0 || busy1 !== 1'b0 || tc1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_recover: ready=%b count=%0d busy=%b tc=%b, expected 1 0 0 0",
                     ready1, count1, busy1, tc1);
        end
    endtask

    task automatic test_oneshot();
        logic [5:0] exp_c [6] = '{6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0};
        send(OP_START, 6'd5, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc();
            tests_run++;
            if (count1 !== exp_c[i] || tc1 !== (i == 5)) begin
                tests_failed++;
                $display("FAIL oneshot_step%0d: count=%0d tc=%b, expected count=%0d tc=%b",
                         i, count1, tc1, exp_c[i], (i == 5));
            end
        end
        tests_run++;
        if (exp1 !== 1'b1 || busy1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL oneshot_done: expired=%b busy=%b, expected 1 0", exp1, busy1);
        end
        cyc();
        tests_run++;
        if (count1 !== 6'd0 || tc1 !== 1'b0 || exp1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL oneshot_hold: count=%0d tc=%b expired=%b, expected 0 0 1", count1, tc1, exp1);
        end
    endtask

    task automatic test_periodic();
        logic [5:0] exp_c [13] = '{6'd3, 6'd3, 6'd2, 6'd2, 6'd1, 6'd1, 6'd3,
                                   6'd3, 6'd2, 6'd2, 6'd1, 6'd1, 6'd3};
        send(OP_ABORT, 6'd0, 1'b0);
        send(OP_START, 6'd3, 1'b1);
        for (int i = 0; i < 13; i++) begin
            if (i > 0) cyc();
            tests_run++;
            if (count2 !== exp_c[i] || tc2 !== (i == 6 || i == 12) || busy2 !== 1'b1) begin
                tests_failed++;
                $display("FAIL periodic_step%0d: count=%0d tc=%b busy=%b, expected count=%0d tc=%b busy=1",
                         i, count2, tc2, busy2, exp_c[i], (i == 6 || i == 12));
            end
        end
    endtask

    task automatic test_pause();
        send(OP_START, 6'd10, 1'b0);
        cyc(); cyc(); cyc();
        tests_run++;
        if (count1 !== 6'd7) begin
            tests_failed++;
            $display("FAIL pause_precount: count=%0d, expected 7", count1);
        end
        send(OP_PAUSE, 6'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            tests_run++;
            if (count1 !== 6'd7 || busy1 !== 1'b1 || err1 !== 1'b0) begin
                tests_failed++;
                $display("FAIL paused_%0d: count=%0d busy=%b err=%b, expected 7 1 0", i, count1, busy1, err1);
            end
        end
        send(OP_RESUME, 6'd0, 1'b0);
        tests_run++;
        if (count1 !== 6'd7 || err1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL resume_accept: count=%0d err=%b, expected 7 0", count1, err1);
        end
        cyc();
        tests_run++;
        if (count1 !== 6'd6) begin
            tests_failed++;
            $display("FAIL resume_6: count=%0d, expected 6", count1);
        end
        cyc();
        tests_run++;
        if (count1 !== 6'd5) begin
            tests_failed++;
            $display("FAIL resume_5: count=%0d, expected 5", count1);
        end
    endtask

    task automatic test_errors();
        send(OP_ABORT, 6'd0, 1'b0);
        send(OP_PAUSE, 6'd0, 1'b0);
        tests_run++;
        if (err1 !== 1'b1 || busy1 !== 1'b0 || count1 !== 6'd0) begin
            tests_failed++;
            $display("FAIL err_pause_idle: err=%b busy=%b count=%0d, expected 1 0 0", err1, busy1, count1);
        end
        cyc();
        tests_run++;
        if (err1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_pulse_width: err=%b, expected 0", err1);
        end
        send(OP_START, 6'd4, 1'b0);
        send(OP_RESUME, 6'd0, 1'b0);
        tests_run++;
        if (err1 !== 1'b1 || busy1 !== 1'b1 || count1 !== 6'd4) begin
            tests_failed++;
            $display("FAIL err_resume_run: err=%b busy=%b count=%0d, expected 1 1 4", err1, busy1, count1);
        end
        cyc();
        tests_run++;
        if (count1 !== 6'd3 || err1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_resume_continue: count=%0d err=%b, expected 3 0", count1, err1);
        end
        send(OP_START, 6'd0, 1'b0);
        tests_run++;
        if (err1 !== 1'b1 || busy1 !== 1'b0 || count1 !== 6'd0 || exp1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_start_zero: err=%b busy=%b count=%0d expired=%b, expected 1 0 0 0",
                     err1, busy1, count1, exp1);
        end
    endtask

    task automatic test_abort();
        send(OP_START, 6'd2, 1'b0);
        cyc();
        tests_run++;
        if (count1 !== 6'd1) begin
            tests_failed++;
            $display("FAIL abort_pre: count=%0d, expected 1", count1);
        end
        send(OP_ABORT, 6'd0, 1'b0);
        tests_run++;
        if (count1 !== 6'd0 || busy1 !== 1'b0 || exp1 !== 1'b0 || tc1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_on_tick: count=%0d busy=%b expired=%b tc=%b, expected 0 0 0 0",
                     count1, busy1, exp1, tc1);
        end
        cyc();
        tests_run++;
        if (tc1 !== 1'b0 || exp1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_no_tc: tc=%b expired=%b, expected 0 0", tc1, exp1);
        end
        send(OP_START, 6'd63, 1'b0);
        tests_run++;
        if (count1 !== 6'd63 || busy1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_max: count=%0d busy=%b, expected 63 1", count1, busy1);
        end
        cyc(); cyc();
        tests_run++;
        if (count1 !== 6'd61) begin
            tests_failed++;
            $display("FAIL start_max_dec: count=%0d, expected 61", count1);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause();
        test_errors();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
